cpu_run_ctrl: RTL and testbench

Execution controller for the CPU core. It generates a one-clock-wide CPU clock enable (cpu_ce) and supports four modes: single-step, free-run, run-N-instructions and halt. It also provides N_BP programmable PC breakpoints and a retired-instruction counter. It sits between the debounced button/switch logic and the CPU datapath, which registers state only on clk edges where cpu_ce=1. It supersedes the button-clocked PC/GPR arrangement and its ad-hoc cycle counter.

---
 rtl/cpu_run_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl -- execution controller for the CPU core.
//
// Produces a one-clock-wide CPU clock enable (cpu_ce) in four modes:
// single-step, free-run, run-N-instructions and halt. It also provides
// N_BP PC breakpoint comparators and a retired-instruction counter. The CPU
// datapath registers state only on clk edges where cpu_ce=1.
//
// Ports:
//   clk          system clock
//   RSTN         asynchronous active-low reset
//   mode         00 step, 01 run, 10 run-N, 11 halt (sampled every cycle)
//   step_pulse   debounced single-cycle step request
//   go           single-cycle pulse: start RUN (modes 01/10) or resume BRK
//   n_steps      instruction count for run-N, sampled on go
//   bp_en        per-comparator breakpoint enable
//   bp_addr      breakpoint addresses, comparator i at [i*PC_W +: PC_W]
//   pc           current CPU PC
//   cpu_rst_req  synchronous CPU reset request (highest priority)
//   cpu_ce       registered CPU enable, one clk wide
//   inst_cnt     enables issued since reset, wraps
//   state        00 IDLE, 01 RUN, 10 BRK
//   halted       1 in IDLE or BRK
//   bp_hit       latched one-hot breakpoint match (lowest index wins)
//   done         one-cycle pulse when a run-N completes
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned PC_W    = 9,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned N_BP    = 2,
  parameter int unsigned RUN_DIV = 4
) (
  input  logic                 clk,
  input  logic                 RSTN,
  input  logic [1:0]           mode,
  input  logic                 step_pulse,
  input  logic                 go,
  input  logic [CNT_W-1:0]     n_steps,
  input  logic [N_BP-1:0]      bp_en,
  input  logic [N_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]      pc,
  input  logic                 cpu_rst_req,
  output logic                 cpu_ce,
  output logic [CNT_W-1:0]     inst_cnt,
  output logic [1:0]           state,
  output logic                 halted,
  output logic [N_BP-1:0]      bp_hit,
  output logic                 done
);

  localparam int unsigned     PS_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

  localparam logic [1:0] MODE_STEP = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_RUNN = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_BRK  = 2'b10
  } state_e;

  state_e            state_q,     state_d;
  logic              cpu_ce_q,    cpu_ce_d;
  logic [CNT_W-1:0]  inst_cnt_q,  inst_cnt_d;
  logic [N_BP-1:0]   bp_hit_q,    bp_hit_d;
  logic              done_q,      done_d;
  logic              halted_q,    halted_d;
  logic [PS_W-1:0]   presc_q,     presc_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              skip_bp_q,   skip_bp_d;
  // Remembers whether the current run was started as run-N, so flipping the
  // mode switch between 01 and 10 mid-run changes nothing until the next go.
  logic              run_n_q,     run_n_d;

  // Breakpoint comparators; disabled comparators never match.
  logic [N_BP-1:0] bp_match;
  logic [N_BP-1:0] bp_first;

  for (genvar i = 0; i < N_BP; i++) begin : g_bp
    assign bp_match[i] = bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc);
  end

  // Isolate the lowest set bit: x & -x.
  assign bp_first = bp_match & (~bp_match + N_BP'(1));

  logic issue_slot;
  assign issue_slot = (presc_q == PS_LAST);

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    cpu_ce_d    = 1'b0;
    inst_cnt_d  = inst_cnt_q;
    bp_hit_d    = bp_hit_q;
    done_d      = 1'b0;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    skip_bp_d   = skip_bp_q;
    run_n_d     = run_n_q;

    if (cpu_rst_req) begin
      // Same end state as RSTN, and it suppresses any enable due this edge.
      state_d     = ST_IDLE;
      inst_cnt_d  = '0;
      bp_hit_d    = '0;
      presc_d     = '0;
      remaining_d = '0;
      skip_bp_d   = 1'b0;
      run_n_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // go outranks step_pulse here; their mode conditions never overlap.
          if (go && mode == MODE_RUN) begin
            state_d   = ST_RUN;
            presc_d   = '0;
            skip_bp_d = 1'b1;
            run_n_d   = 1'b0;
          end else if (go && mode == MODE_RUNN) begin
            if (n_steps == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = ST_RUN;
              remaining_d = n_steps;
              presc_d     = '0;
              skip_bp_d   = 1'b1;
              run_n_d     = 1'b1;
            end
          end else if (step_pulse && mode == MODE_STEP) begin
            cpu_ce_d = 1'b1;
          end
        end

        ST_RUN: begin
          if (mode == MODE_HALT) begin
            // Halt wins even over an issue slot on this edge.
            state_d = ST_IDLE;
          end else if (issue_slot) begin
            presc_d = '0;
            if (!skip_bp_q && (bp_match != '0)) begin
              bp_hit_d = bp_first;
              state_d  = ST_BRK;
            end else begin
              // skip_bp lets the instruction we just resumed at execute once.
              cpu_ce_d  = 1'b1;
              skip_bp_d = 1'b0;
              if (run_n_q) begin
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end
              end
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end

        ST_BRK: begin
          // Step outranks halt, which outranks resume: a level-held halt
          // switch should not let a go pulse slip back into RUN.
          if (step_pulse) begin
            cpu_ce_d = 1'b1;
            bp_hit_d = '0;
            state_d  = ST_IDLE;
          end else if (mode == MODE_HALT) begin
            bp_hit_d = '0;
            state_d  = ST_IDLE;
          end else if (go) begin
            bp_hit_d  = '0;
            state_d   = ST_RUN;
            presc_d   = '0;
            skip_bp_d = 1'b1;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      // Count in the same edge that raises cpu_ce, so inst_cnt always equals
      // the number of enable pulses already visible on the output.
      if (cpu_ce_d) begin
        inst_cnt_d = inst_cnt_q + CNT_W'(1);
      end
    end

    halted_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    // NOTE: this controller holds only a handful of control flops (no
    // storage arrays), so every one of them is given a reset value.
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      cpu_ce_q    <= 1'b0;
      inst_cnt_q  <= '0;
      bp_hit_q    <= '0;
      done_q      <= 1'b0;
      halted_q    <= 1'b1;
      presc_q     <= '0;
      remaining_q <= '0;
      skip_bp_q   <= 1'b0;
      run_n_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its _d value
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      inst_cnt_q  <= inst_cnt_d;
      bp_hit_q    <= bp_hit_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      skip_bp_q   <= skip_bp_d;
      run_n_q     <= run_n_d;
    end
  end

  assign cpu_ce   = cpu_ce_q;
  assign inst_cnt = inst_cnt_q;
  assign state    = state_q;
  assign halted   = halted_q;
  assign bp_hit   = bp_hit_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl -- self-checking bench for cpu_run_ctrl.
//
// A behavioural model predicts, edge by edge, every visible output event
// (enable, done, state change, counter change) and queues it. A monitor
// compares what the DUT presents against the queue. A small CPU stand-in
// advances pc on each enable. CNT_W is 4 so counter wrap is reached quickly.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  localparam int PC_W    = 9;
  localparam int CNT_W   = 4;
  localparam int N_BP    = 2;
  localparam int RUN_DIV = 4;

  logic                 clk = 1'b0;
  logic                 RSTN = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic                 step_pulse = 1'b0;
  logic                 go = 1'b0;
  logic [CNT_W-1:0]     n_steps = '0;
  logic [N_BP-1:0]      bp_en = '0;
  logic [N_BP*PC_W-1:0] bp_addr = '0;
  logic [PC_W-1:0]      pc;
  logic                 cpu_rst_req = 1'b0;
  logic                 cpu_ce;
  logic [CNT_W-1:0]     inst_cnt;
  logic [1:0]           state;
  logic                 halted;
  logic [N_BP-1:0]      bp_hit;
  logic                 done;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .N_BP(N_BP), .RUN_DIV(RUN_DIV)
  ) dut (
    .clk(clk), .RSTN(RSTN), .mode(mode), .step_pulse(step_pulse), .go(go),
    .n_steps(n_steps), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_rst_req(cpu_rst_req), .cpu_ce(cpu_ce), .inst_cnt(inst_cnt),
    .state(state), .halted(halted), .bp_hit(bp_hit), .done(done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU stand-in: the PC advances on every enabled edge, resets with the CPU.
  always @(posedge clk or negedge RSTN) begin
    if (!RSTN)            pc <= '0;
    else if (cpu_rst_req) pc <= '0;
    else if (cpu_ce)      pc <= pc + 1'b1;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int              cyc;
    logic            ce;
    logic            dn;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      st;
    logic [N_BP-1:0] hit;
    logic            halted;
  } exp_t;

  exp_t sb[$];

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_BRK} m_st_e;

  m_st_e           m_st = M_IDLE;
  int              m_next = 0;    // absolute edge number of the next issue slot
  int              m_left = 0;    // instructions still owed in run-N
  bit              m_skip = 1'b0;
  bit              m_nrun = 1'b0;
  logic [N_BP-1:0] m_hit = '0;
  int              m_cnt = 0;
  int              m_pc = 0;
  bit              m_ce_prev = 1'b0;

  function automatic logic [1:0] st_code(input m_st_e s);
    case (s)
      M_RUN:   return 2'b01;
      M_BRK:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic m_step(input int e, input logic [1:0] md, input bit st, input bit g,
                        input logic [CNT_W-1:0] n, input bit rq);
    m_st_e old_st;
    int    old_cnt;
    bit    ce;
    bit    dn;
    int    hit_idx;
    exp_t  x;
    old_st  = m_st;
    old_cnt = m_cnt;
    ce      = 1'b0;
    dn      = 1'b0;
    if (rq) begin
      m_st = M_IDLE; m_hit = '0; m_skip = 1'b0; m_left = 0; m_cnt = 0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (g && md == 2'b01) begin
            m_st = M_RUN; m_nrun = 1'b0; m_skip = 1'b1; m_next = e + RUN_DIV;
          end else if (g && md == 2'b10) begin
            if (n == '0) dn = 1'b1;
            else begin
              m_left = int'(n); m_nrun = 1'b1; m_st = M_RUN; m_skip = 1'b1;
              m_next = e + RUN_DIV;
            end
          end else if (st && md == 2'b00) begin
            ce = 1'b1;
          end
        end
        M_RUN: begin
          if (md == 2'b11) begin
            m_st = M_IDLE;
          end else if (e == m_next) begin
            m_next  = e + RUN_DIV;
            hit_idx = -1;
            for (int i = 0; i < N_BP; i++)
              if (hit_idx < 0 && bp_en[i] && int'(bp_addr[i*PC_W +: PC_W]) == m_pc) hit_idx = i;
            if (!m_skip && hit_idx >= 0) begin
              m_hit = '0;
              m_hit[hit_idx] = 1'b1;
              m_st = M_BRK;
            end else begin
              ce = 1'b1;
              m_skip = 1'b0;
              if (m_nrun) begin
                m_left--;
                if (m_left == 0) begin
                  dn = 1'b1;
                  m_st = M_IDLE;
                end
              end
            end
          end
        end
        default: begin // M_BRK
          if (st) begin
            ce = 1'b1; m_hit = '0; m_st = M_IDLE;
          end else if (md == 2'b11) begin
            m_hit = '0; m_st = M_IDLE;
          end else if (g) begin
            m_hit = '0; m_st = M_RUN; m_skip = 1'b1; m_next = e + RUN_DIV;
          end
        end
      endcase
    end
    if (ce) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    // The CPU's PC moves on this edge if the enable was high before it.
    if (rq)             m_pc = 0;
    else if (m_ce_prev) m_pc = (m_pc + 1) % (1 << PC_W);
    m_ce_prev = ce;
    if (ce || dn || m_st != old_st || m_cnt != old_cnt) begin
      x.cyc    = e;
      x.ce     = ce;
      x.dn     = dn;
      x.cnt    = CNT_W'(m_cnt);
      x.st     = st_code(m_st);
      x.hit    = m_hit;
      x.halted = (m_st != M_RUN);
      sb.push_back(x);
    end
  endtask

  // ---------------- monitor ----------------
  bit               mon_en = 1'b0;
  logic [1:0]       prev_st = 2'b00;
  logic [CNT_W-1:0] prev_cnt = '0;

  always @(negedge clk) begin
    exp_t x;
    bit   ev;
    bit   have;
    if (mon_en) begin
      ev   = cpu_ce || done || (state != prev_st) || (inst_cnt != prev_cnt);
      have = (sb.size() > 0) && (sb[0].cyc == cyc);
      if (ev || have) begin
        check("event_present", 32'(ev), 32'(have));
        if (have) begin
          x = sb.pop_front();
          if (ev) begin
            check("cpu_ce",   32'(cpu_ce),   32'(x.ce));
            check("done",     32'(done),     32'(x.dn));
            check("inst_cnt", 32'(inst_cnt), 32'(x.cnt));
            check("state",    32'(state),    32'(x.st));
            check("bp_hit",   32'(bp_hit),   32'(x.hit));
            check("halted",   32'(halted),   32'(x.halted));
          end
        end
      end
      prev_st  = state;
      prev_cnt = inst_cnt;
    end
  end

  // ---------------- stimulus ----------------
  bit                   halt_at_slot = 1'b0;
  bit                   rst_at_slot  = 1'b0;
  logic [N_BP-1:0]      nxt_bp_en   = '0;
  logic [N_BP*PC_W-1:0] nxt_bp_addr = '0;

  // Drives one edge's worth of inputs and advances the model for that edge.
  task automatic tick(input logic [1:0] md, input bit st, input bit g,
                      input logic [CNT_W-1:0] n, input bit rq);
    int         e;
    logic [1:0] m;
    bit         r;
    m = md;
    r = rq;
    @(negedge clk);
    e = cyc + 1;
    if (m_st == M_RUN && e == m_next) begin
      if (halt_at_slot) begin m = 2'b11; halt_at_slot = 1'b0; end
      if (rst_at_slot)  begin r = 1'b1;  rst_at_slot  = 1'b0; end
    end
    bp_en       = nxt_bp_en;
    bp_addr     = nxt_bp_addr;
    mode        = m;
    step_pulse  = st;
    go          = g;
    n_steps     = n;
    cpu_rst_req = r;
    m_step(e, m, st, g, n, r);
  endtask

  task automatic idle(input int k, input logic [1:0] md);
    repeat (k) tick(md, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [1:0]       r_mode;
    logic [PC_W-1:0]  a0;
    logic [PC_W-1:0]  a1;

    repeat (2) @(negedge clk);
    RSTN   = 1'b1;
    mon_en = 1'b1;
    m_step(cyc + 1, 2'b00, 1'b0, 1'b0, '0, 1'b0);

    // Reset state.
    check("rst_state",    32'(state),    32'h0);
    check("rst_cpu_ce",   32'(cpu_ce),   32'h0);
    check("rst_inst_cnt", 32'(inst_cnt), 32'h0);
    check("rst_bp_hit",   32'(bp_hit),   32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_halted",   32'(halted),   32'h1);

    // Three single steps, spaced five cycles apart.
    repeat (3) begin
      tick(2'b00, 1'b1, 1'b0, '0, 1'b0);
      idle(4, 2'b00);
    end
    check("step_inst_cnt", 32'(inst_cnt), 32'd3);
    check("step_state",    32'(state),    32'h0);

    // CPU reset clears the counter and the PC.
    tick(2'b00, 1'b0, 1'b0, '0, 1'b1);
    idle(2, 2'b00);
    check("rstreq_inst_cnt", 32'(inst_cnt), 32'h0);

    // Free run into a breakpoint at PC 5.
    nxt_bp_en   = 2'b01;
    nxt_bp_addr = '0;
    nxt_bp_addr[0 +: PC_W] = PC_W'(5);
    tick(2'b01, 1'b0, 1'b1, '0, 1'b0);
    idle(30, 2'b01);
    check("brk_state",    32'(state),    32'h2);
    check("brk_bp_hit",   32'(bp_hit),   32'h1);
    check("brk_inst_cnt", 32'(inst_cnt), 32'd5);
    check("brk_halted",   32'(halted),   32'h1);
    check("brk_pc",       32'(pc),       32'd5);

    // Resume: the instruction at PC 5 runs once and the run continues.
    tick(2'b01, 1'b0, 1'b1, '0, 1'b0);
    idle(20, 2'b01);
    check("resume_state",  32'(state),  32'h1);
    check("resume_bp_hit", 32'(bp_hit), 32'h0);
    tick(2'b11, 1'b0, 1'b0, '0, 1'b0);
    idle(3, 2'b00);
    check("halt_state", 32'(state), 32'h0);

    // Run-N with three instructions, then n_steps=0.
    nxt_bp_en = '0;
    tick(2'b00, 1'b0, 1'b0, '0, 1'b1);
    tick(2'b10, 1'b0, 1'b1, CNT_W'(3), 1'b0);
    idle(20, 2'b10);
    check("runn_inst_cnt", 32'(inst_cnt), 32'd3);
    check("runn_state",    32'(state),    32'h0);
    tick(2'b10, 1'b0, 1'b1, '0, 1'b0);
    idle(5, 2'b10);
    check("runn0_inst_cnt", 32'(inst_cnt), 32'd3);

    // Halt landing exactly on an issue slot: no enable on that edge.
    halt_at_slot = 1'b1;
    tick(2'b01, 1'b0, 1'b1, '0, 1'b0);
    idle(10, 2'b01);
    check("slot_halt_state",  32'(state),    32'h0);
    check("slot_halt_halted", 32'(halted),   32'h1);
    check("slot_halt_cnt",    32'(inst_cnt), 32'd3);

    // CPU reset landing on an issue slot.
    rst_at_slot = 1'b1;
    tick(2'b01, 1'b0, 1'b1, '0, 1'b0);
    idle(10, 2'b01);
    check("slot_rst_cnt",   32'(inst_cnt), 32'h0);
    check("slot_rst_state", 32'(state),    32'h0);

    // 17 instructions on a 4-bit counter wraps to 1.
    tick(2'b10, 1'b0, 1'b1, CNT_W'(15), 1'b0);
    idle(70, 2'b10);
    repeat (2) begin
      tick(2'b00, 1'b1, 1'b0, '0, 1'b0);
      idle(4, 2'b00);
    end
    check("wrap_inst_cnt", 32'(inst_cnt), 32'd1);

    // Randomized traffic against the model.
    r_mode = 2'b01;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(15) == 0) r_mode = 2'($urandom_range(3));
      if ($urandom_range(149) == 0) begin
        nxt_bp_en = N_BP'($urandom_range(3));
        a0 = PC_W'($urandom_range(20));
        a1 = PC_W'($urandom_range(20));
        nxt_bp_addr = {a1, a0};
      end
      tick(r_mode, ($urandom_range(9) == 0), ($urandom_range(9) == 0),
           CNT_W'($urandom_range(5)), ($urandom_range(299) == 0));
    end

    idle(3, 2'b11);
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
